fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the 16-bit 5-stage core.

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory/cache read handshake between the fetch stage and imem.
// The fetch stage is the master: it raises imem_req with imem_addr and holds
// both until the one-cycle imem_done pulse returns imem_rdata.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_done
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_done
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the 16-bit core.
// Owns the PC, runs the variable-latency imem handshake, parks a word in a
// one-entry skid buffer during load-use stalls, drains orphaned requests after
// a redirect and stops fetching once a HALT has been delivered.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [4:0]  HALT_OPC  = 5'b00000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard_stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [15:0]          PC_val,
    output logic [15:0]          PC_next,
    output logic [15:0]          ID_Instr_out,
    output logic [15:0]          ID_pc_2_w_out,
    output logic                 ID_halt_out,
    output logic                 ID_valid_out,
    output logic                 halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc2_q, id_pc2_d;
    logic        id_halt_q, id_halt_d;
    logic        id_valid_q, id_valid_d;
    logic        skid_full_q, skid_full_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
    logic        skid_halt_q, skid_halt_d;

    logic [15:0] pc_plus2;
    logic        deliver;
    logic        word_is_halt;
    logic        outstanding;

    assign pc_plus2     = pc_q + 16'd2;
    assign word_is_halt = (imem.imem_rdata[15:11] == HALT_OPC);
    // A request is still in flight when it is raised and no done has come back.
    assign outstanding  = req_q && !imem.imem_done;
    assign deliver      = req_q && imem.imem_done &&
                          ((state_q == S_FETCH) || (state_q == S_WAIT));

    // Next-state logic: redirect first, then delivery / skid drain / bubbles.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_instr_d   = id_instr_q;
        id_pc2_d     = id_pc2_q;
        id_halt_d    = id_halt_q;
        id_valid_d   = id_valid_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
        skid_halt_d  = skid_halt_q;

        if (redirect) begin
            pc_d        = redirect_pc;
            id_instr_d  = NOP_INSTR;
            id_halt_d   = 1'b0;
            id_valid_d  = 1'b0;
            skid_full_d = 1'b0;
            state_d     = (outstanding && (state_q != S_HALTED)) ? S_DRAIN : S_FETCH;
        end else begin
            if (deliver) begin
                pc_d    = pc_plus2;
                state_d = word_is_halt ? S_HALTED : S_FETCH;
            end else if (outstanding && (state_q == S_FETCH)) begin
                state_d = S_WAIT;
            end else if (req_q && imem.imem_done && (state_q == S_DRAIN)) begin
                state_d = S_FETCH;
            end

            if (!hazard_stall) begin
                if (deliver) begin
                    id_instr_d = imem.imem_rdata;
                    id_pc2_d   = pc_plus2;
                    id_halt_d  = word_is_halt;
                    id_valid_d = 1'b1;
                end else if (skid_full_q) begin
                    id_instr_d  = skid_instr_q;
                    id_pc2_d    = skid_pc2_q;
                    id_halt_d   = skid_halt_q;
                    id_valid_d  = 1'b1;
                    skid_full_d = 1'b0;
                end else begin
                    id_instr_d = NOP_INSTR;
                    id_halt_d  = 1'b0;
                    id_valid_d = 1'b0;
                end
            end else if (deliver) begin
                skid_instr_d = imem.imem_rdata;
                skid_pc2_d   = pc_plus2;
                skid_halt_d  = word_is_halt;
                skid_full_d  = 1'b1;
            end
        end

        // The address is frozen while a request is in flight (including DRAIN,
        // where the PC already holds the redirect target); otherwise it tracks
        // the PC that the next request will use.
        req_d  = (state_d != S_HALTED) && !skid_full_d;
        addr_d = outstanding ? addr_q : pc_d;
    end

    // State, PC, handshake and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc2_q     <= '0;
            id_halt_q    <= 1'b0;
            id_valid_q   <= 1'b0;
            skid_full_q  <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc2_q   <= '0;
            skid_halt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            id_instr_q   <= id_instr_d;
            id_pc2_q     <= id_pc2_d;
            id_halt_q    <= id_halt_d;
            id_valid_q   <= id_valid_d;
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
            skid_halt_q  <= skid_halt_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign PC_val         = pc_q;
    assign PC_next        = pc_plus2;
    assign ID_Instr_out   = id_instr_q;
    assign ID_pc_2_w_out  = id_pc2_q;
    assign ID_halt_out    = id_halt_q;
    assign ID_valid_out   = id_valid_q;
    assign halted         = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory, answering
// each request with a word derived from its address, and checks IF/ID, PC and
// handshake outputs against hand-computed values one cycle at a time.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        hazard_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] PC_val;
    logic [15:0] PC_next;
    logic [15:0] ID_Instr_out;
    logic [15:0] ID_pc_2_w_out;
    logic        ID_halt_out;
    logic        ID_valid_out;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic        halt_en   = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .HALT_OPC  (5'b00000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_stall  (hazard_stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem          (imem_bus.master),
        .PC_val        (PC_val),
        .PC_next       (PC_next),
        .ID_Instr_out  (ID_Instr_out),
        .ID_pc_2_w_out (ID_pc_2_w_out),
        .ID_halt_out   (ID_halt_out),
        .ID_valid_out  (ID_valid_out),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Memory contents: opcode 10101 plus the low address bits; HALT word when enabled.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_en && (a == halt_addr)) return 16'h07FF;
        return {5'b10101, a[10:0]};
    endfunction

    // One clock: answer the current request (done only if requested), then
    // sample 1 time unit after the rising edge.
    task automatic step(input logic d);
        imem_bus.imem_done  = d & imem_bus.imem_req;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        hazard_stall = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 16'h0000;
        imem_bus.imem_done  = 1'b0;
        imem_bus.imem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", imem_bus.imem_req); end
        n_checks++; if (PC_val !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", PC_val); end
        n_checks++; if (PC_next !== 16'h0002) begin n_fail++; $display("FAIL reset_pc_next: got %h expected 0002", PC_next); end
        n_checks++; if (ID_Instr_out !== 16'h0800) begin n_fail++; $display("FAIL reset_instr: got %h expected 0800", ID_Instr_out); end
        n_checks++; if (ID_pc_2_w_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc2: got %h expected 0000", ID_pc_2_w_out); end
        n_checks++; if (ID_valid_out !== 1'b0 || ID_halt_out !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got valid=%0b halt=%0b halted=%0b expected 0 0 0", ID_valid_out, ID_halt_out, halted); end
        rst = 1'b0;
        step(1'b0);
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_req: got req=%0b addr=%h expected 1 0000", imem_bus.imem_req, imem_bus.imem_addr); end
        n_checks++; if (ID_valid_out !== 1'b0) begin n_fail++; $display("FAIL first_bubble: got valid=%0b expected 0", ID_valid_out); end
    endtask

    task automatic test_hits();
        step(1'b1);
        n_checks++; if (ID_valid_out !== 1'b1 || ID_Instr_out !== 16'hA800 || ID_pc_2_w_out !== 16'h0002) begin n_fail++; $display("FAIL hit0: got v=%0b instr=%h pc2=%h expected 1 A800 0002", ID_valid_out, ID_Instr_out, ID_pc_2_w_out); end
        step(1'b1);
        n_checks++; if (ID_valid_out !== 1'b1 || ID_Instr_out !== 16'hA802 || ID_pc_2_w_out !== 16'h0004) begin n_fail++; $display("FAIL hit1: got v=%0b instr=%h pc2=%h expected 1 A802 0004", ID_valid_out, ID_Instr_out, ID_pc_2_w_out); end
        step(1'b1);
        n_checks++; if (ID_valid_out !== 1'b1 || ID_Instr_out !== 16'hA804 || ID_pc_2_w_out !== 16'h0006) begin n_fail++; $display("FAIL hit2: got v=%0b instr=%h pc2=%h expected 1 A804 0006", ID_valid_out, ID_Instr_out, ID_pc_2_w_out); end
        n_checks++; if (PC_val !== 16'h0006 || imem_bus.imem_addr !== 16'h0006) begin n_fail++; $display("FAIL hit_pc: got pc=%h addr=%h expected 0006 0006", PC_val, imem_bus.imem_addr); end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0006) begin n_fail++; $display("FAIL miss_addr%0d: got req=%0b addr=%h expected 1 0006", i, imem_bus.imem_req, imem_bus.imem_addr); end
            step(i == 2);
            if (i < 2) begin
                n_checks++; if (ID_valid_out !== 1'b0) begin n_fail++; $display("FAIL miss_bubble%0d: got valid=%0b expected 0", i, ID_valid_out); end
            end
        end
        n_checks++; if (ID_valid_out !== 1'b1 || ID_Instr_out !== 16'hA806 || ID_pc_2_w_out !== 16'h0008) begin n_fail++; $display("FAIL miss_deliver: got v=%0b instr=%h pc2=%h expected 1 A806 0008", ID_valid_out, ID_Instr_out, ID_pc_2_w_out); end
    endtask

    task automatic test_stall();
        hazard_stall = 1'b1;
        step(1'b1);
        n_checks++; if (ID_Instr_out !== 16'hA806 || ID_pc_2_w_out !== 16'h0008 || ID_valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_hold0: got instr=%h pc2=%h v=%0b expected A806 0008 1", ID_Instr_out, ID_pc_2_w_out, ID_valid_out); end
        n_checks++; if (imem_bus.imem_req !== 1'b0 || PC_val !== 16'h000A) begin n_fail++; $display("FAIL stall_skid: got req=%0b pc=%h expected 0 000A", imem_bus.imem_req, PC_val); end
        step(1'b1);
        n_checks++; if (ID_Instr_out !== 16'hA806 || imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold1: got instr=%h req=%0b expected A806 0", ID_Instr_out, imem_bus.imem_req); end
        hazard_stall = 1'b0;
        step(1'b0);
        n_checks++; if (ID_Instr_out !== 16'hA808 || ID_pc_2_w_out !== 16'h000A || ID_valid_out !== 1'b1) begin n_fail++; $display("FAIL skid_drain: got instr=%h pc2=%h v=%0b expected A808 000A 1", ID_Instr_out, ID_pc_2_w_out, ID_valid_out); end
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h000A) begin n_fail++; $display("FAIL skid_resume: got req=%0b addr=%h expected 1 000A", imem_bus.imem_req, imem_bus.imem_addr); end
        step(1'b1);
        n_checks++; if (ID_Instr_out !== 16'hA80A || ID_pc_2_w_out !== 16'h000C) begin n_fail++; $display("FAIL after_skid: got instr=%h pc2=%h expected A80A 000C", ID_Instr_out, ID_pc_2_w_out); end
    endtask

    task automatic test_redirect_drain();
        step(1'b0);
        n_checks++; if (ID_valid_out !== 1'b0) begin n_fail++; $display("FAIL wait_bubble: got valid=%0b expected 0", ID_valid_out); end
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step(1'b0);
        redirect = 1'b0;
        n_checks++; if (PC_val !== 16'h0040 || imem_bus.imem_addr !== 16'h000C || imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_enter: got pc=%h addr=%h req=%0b expected 0040 000C 1", PC_val, imem_bus.imem_addr, imem_bus.imem_req); end
        n_checks++; if (ID_valid_out !== 1'b0 || ID_Instr_out !== 16'h0800) begin n_fail++; $display("FAIL redirect_flush: got v=%0b instr=%h expected 0 0800", ID_valid_out, ID_Instr_out); end
        step(1'b0);
        n_checks++; if (imem_bus.imem_addr !== 16'h000C) begin n_fail++; $display("FAIL drain_hold: got addr=%h expected 000C", imem_bus.imem_addr); end
        step(1'b1);
        n_checks++; if (ID_valid_out !== 1'b0 || ID_Instr_out !== 16'h0800) begin n_fail++; $display("FAIL drain_discard: got v=%0b instr=%h expected 0 0800", ID_valid_out, ID_Instr_out); end
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL drain_refetch: got req=%0b addr=%h expected 1 0040", imem_bus.imem_req, imem_bus.imem_addr); end
        step(1'b1);
        n_checks++; if (ID_valid_out !== 1'b1 || ID_Instr_out !== 16'hA840 || ID_pc_2_w_out !== 16'h0042) begin n_fail++; $display("FAIL target_deliver: got v=%0b instr=%h pc2=%h expected 1 A840 0042", ID_valid_out, ID_Instr_out, ID_pc_2_w_out); end
    endtask

    task automatic test_halt();
        halt_en   = 1'b1;
        halt_addr = 16'h0044;
        step(1'b1);
        n_checks++; if (ID_Instr_out !== 16'hA842 || ID_halt_out !== 1'b0) begin n_fail++; $display("FAIL pre_halt: got instr=%h halt=%0b expected A842 0", ID_Instr_out, ID_halt_out); end
        step(1'b1);
        n_checks++; if (ID_halt_out !== 1'b1 || ID_valid_out !== 1'b1 || ID_pc_2_w_out !== 16'h0046) begin n_fail++; $display("FAIL halt_deliver: got halt=%0b v=%0b pc2=%h expected 1 1 0046", ID_halt_out, ID_valid_out, ID_pc_2_w_out); end
        n_checks++; if (halted !== 1'b1 || imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_stop: got halted=%0b req=%0b expected 1 0", halted, imem_bus.imem_req); end
        step(1'b1);
        step(1'b1);
        n_checks++; if (halted !== 1'b1 || imem_bus.imem_req !== 1'b0 || PC_val !== 16'h0046) begin n_fail++; $display("FAIL halt_frozen: got halted=%0b req=%0b pc=%h expected 1 0 0046", halted, imem_bus.imem_req, PC_val); end
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step(1'b0);
        redirect = 1'b0;
        halt_en  = 1'b0;
        n_checks++; if (halted !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0010 || PC_val !== 16'h0010) begin n_fail++; $display("FAIL halt_resume: got halted=%0b req=%0b addr=%h pc=%h expected 0 1 0010 0010", halted, imem_bus.imem_req, imem_bus.imem_addr, PC_val); end
        step(1'b1);
        n_checks++; if (ID_Instr_out !== 16'hA810 || ID_pc_2_w_out !== 16'h0012 || ID_valid_out !== 1'b1) begin n_fail++; $display("FAIL resume_deliver: got instr=%h pc2=%h v=%0b expected A810 0012 1", ID_Instr_out, ID_pc_2_w_out, ID_valid_out); end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step(1'b1);
        redirect = 1'b0;
        n_checks++; if (PC_val !== 16'hFFFE || PC_next !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc_next: got pc=%h next=%h expected FFFE 0000", PC_val, PC_next); end
        n_checks++; if (imem_bus.imem_addr !== 16'hFFFE || ID_valid_out !== 1'b0) begin n_fail++; $display("FAIL wrap_redirect: got addr=%h v=%0b expected FFFE 0", imem_bus.imem_addr, ID_valid_out); end
        step(1'b1);
        n_checks++; if (ID_Instr_out !== 16'hAFFE || ID_pc_2_w_out !== 16'h0000 || imem_bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_fetch: got instr=%h pc2=%h addr=%h expected AFFE 0000 0000", ID_Instr_out, ID_pc_2_w_out, imem_bus.imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        step(1'b1);
        step(1'b0);
        n_checks++; if (PC_val !== 16'h0002 || imem_bus.imem_addr !== 16'h0002 || ID_valid_out !== 1'b0) begin n_fail++; $display("FAIL pre_reset_wait: got pc=%h addr=%h v=%0b expected 0002 0002 0", PC_val, imem_bus.imem_addr, ID_valid_out); end
        rst = 1'b1;
        #1;
        n_checks++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 16'h0000 || PC_val !== 16'h0000) begin n_fail++; $display("FAIL async_reset_pc: got req=%0b addr=%h pc=%h expected 0 0000 0000", imem_bus.imem_req, imem_bus.imem_addr, PC_val); end
        n_checks++; if (ID_Instr_out !== 16'h0800 || ID_pc_2_w_out !== 16'h0000 || ID_valid_out !== 1'b0 || ID_halt_out !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_reset_ifid: got instr=%h pc2=%h v=%0b h=%0b halted=%0b expected 0800 0000 0 0 0", ID_Instr_out, ID_pc_2_w_out, ID_valid_out, ID_halt_out, halted); end
        rst = 1'b0;
        step(1'b0);
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL post_reset_req: got req=%0b addr=%h expected 1 0000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_hits();
        test_miss();
        test_stall();
        test_redirect_drain();
        test_halt();
        test_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
